d16_decode_pipe: RTL and testbench

Registered, flow-controlled instruction decode stage for the d16 core. It is parametrised in datapath width and immediate-extension mode and sits between instruction fetch and the register-read/execute stages. It splits a 32-bit instruction word into the opcode and three W-bit operand fields, and flags opcodes it does not know. A two-entry skid buffer gives full throughput, and `in_ready` has no combinational dependence on `out_ready`.

---
 rtl/d16_decode_if.sv | 30 +++
 rtl/d16_decode_pipe.sv | 174 +++++++++++++++++
 tb/tb_d16_decode_pipe.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/d16_decode_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | d16_decode_if : fetch-side and execute-side handshake bundle for   |
// |                 the d16 decode stage.            Revision: 1.0     |
// +------------------------------------------------------------------+
interface d16_decode_if #(
   parameter int W = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_instr;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_op;
   logic [W-1:0]  out_a;
   logic [W-1:0]  out_b;
   logic [W-1:0]  out_c;
   logic          out_illegal;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_op, out_a, out_b, out_c, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_op, out_a, out_b, out_c, out_illegal
   );
endinterface
`default_nettype wire

// File: rtl/d16_decode_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | d16_decode_pipe : registered d16 instruction decode with a       |
// |                   two-entry skid buffer.         Revision: 1.0     |
// +------------------------------------------------------------------+
module d16_decode_pipe #(
   parameter int W          = 16,
   parameter bit SIGNED_IMM = 1'b0
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        flush,
   d16_decode_if.slave bus
);

   localparam logic [7:0] C_OP_ADD = 8'h01;
   localparam logic [7:0] C_OP_SUB = 8'h02;
   localparam logic [7:0] C_OP_SHL = 8'h03;
   localparam logic [7:0] C_OP_SHR = 8'h04;
   localparam logic [7:0] C_OP_OR  = 8'h05;
   localparam logic [7:0] C_OP_AND = 8'h06;
   localparam logic [7:0] C_OP_EQU = 8'h07;
   localparam logic [7:0] C_OP_LTE = 8'h08;
   localparam logic [7:0] C_OP_GTE = 8'h09;
   localparam logic [7:0] C_OP_LT  = 8'h0A;
   localparam logic [7:0] C_OP_GT  = 8'h0B;
   localparam logic [7:0] C_OP_AFC = 8'h0C;
   localparam logic [7:0] C_OP_COP = 8'h0D;
   localparam logic [7:0] C_OP_LOP = 8'h0E;
   localparam logic [7:0] C_OP_STP = 8'h0F;
   localparam logic [7:0] C_OP_LOD = 8'h10;
   localparam logic [7:0] C_OP_STR = 8'h11;
   localparam logic [7:0] C_OP_JMP = 8'h12;
   localparam logic [7:0] C_OP_JMZ = 8'h13;

   if (W < 16) begin : g_bad_width
      $error("d16_decode_pipe: W must be at least 16");
   end

   typedef struct packed {
      logic [7:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
      logic         illegal;
   } dec_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   dec_t        m_q, m_d;
   dec_t        s_q, s_d;
   dec_t        dec;
   logic [7:0]  op, fa, fb, fc;
   logic [15:0] imm;
   logic        in_ready;
   logic        accept;
   logic        pop;

   assign op  = bus.in_instr[31:24];
   assign fa  = bus.in_instr[23:16];
   assign fb  = bus.in_instr[15:8];
   assign fc  = bus.in_instr[7:0];
   assign imm = {fb, fc};

   always_comb begin : p_decode
      dec    = '0;
      dec.op = op;
      case (op)
         C_OP_ADD, C_OP_SUB, C_OP_SHL, C_OP_SHR, C_OP_OR, C_OP_AND,
         C_OP_EQU, C_OP_LTE, C_OP_GTE, C_OP_LT, C_OP_GT: begin
            dec.a = W'(fa);
            dec.b = W'(fb);
            dec.c = W'(fc);
         end
         C_OP_AFC, C_OP_LOD: begin
            dec.a = W'(fa);
            dec.b = SIGNED_IMM ? W'($signed(imm)) : W'(imm);
         end
         C_OP_COP: begin
            dec.a = W'(fa);
            dec.b = W'(fb);
         end
         C_OP_LOP: begin
            dec.a = W'(fa);
            dec.b = W'($signed(fb));
            dec.c = W'(fc);
         end
         C_OP_STP: begin
            dec.a = W'($signed(fa));
            dec.b = W'(fb);
            dec.c = W'(fc);
         end
         // Addresses are never sign-extended, whatever SIGNED_IMM says.
         C_OP_STR, C_OP_JMZ: begin
            dec.a = W'({fa, fb});
            dec.b = W'(fc);
         end
         C_OP_JMP: begin
            dec.a = W'({fa, fb});
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   // Ready is a function of registered state only, never of out_ready.
   assign in_ready = (state_q != TWO) && !flush && !sys_rst;
   assign accept   = bus.in_valid && in_ready;
   assign pop      = (state_q != EMPTY) && bus.out_ready;

   always_comb begin : p_next
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               m_d     = dec;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && !pop) begin
               s_d     = dec;
               state_d = TWO;
            end else if (!accept && pop) begin
               state_d = EMPTY;
            end else if (accept && pop) begin
               m_d = dec;
            end
         end
         TWO: begin
            if (pop) begin
               m_d     = s_q;
               state_d = ONE;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      if (flush) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge sys_clk) begin : p_state
      if (sys_rst) begin
         state_q <= EMPTY;
         m_q     <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         s_q     <= s_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = (state_q != EMPTY);
   assign bus.out_op      = m_q.op;
   assign bus.out_a       = m_q.a;
   assign bus.out_b       = m_q.b;
   assign bus.out_c       = m_q.c;
   assign bus.out_illegal = m_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_d16_decode_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_d16_decode_pipe : bench for d16_decode_pipe at W=16/unsigned  |
// |                      and W=32/signed immediates.  Revision: 1.0    |
// +------------------------------------------------------------------+
module tb_d16_decode_pipe;

   localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_SHL = 8'h03, OP_SHR = 8'h04;
   localparam logic [7:0] OP_OR  = 8'h05, OP_AND = 8'h06, OP_EQU = 8'h07, OP_LTE = 8'h08;
   localparam logic [7:0] OP_GTE = 8'h09, OP_LT  = 8'h0A, OP_GT  = 8'h0B, OP_AFC = 8'h0C;
   localparam logic [7:0] OP_COP = 8'h0D, OP_LOP = 8'h0E, OP_STP = 8'h0F, OP_LOD = 8'h10;
   localparam logic [7:0] OP_STR = 8'h11, OP_JMP = 8'h12, OP_JMZ = 8'h13;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;

   always #5 clk = ~clk;

   d16_decode_if #(.W(16)) bus16 ();
   d16_decode_if #(.W(32)) bus32 ();

   assign bus16.in_valid  = in_valid;
   assign bus16.in_instr  = in_instr;
   assign bus16.out_ready = out_ready;
   assign bus32.in_valid  = in_valid;
   assign bus32.in_instr  = in_instr;
   assign bus32.out_ready = out_ready;

   d16_decode_pipe #(.W(16), .SIGNED_IMM(1'b0)) u_dut16 (
      .sys_clk (clk),
      .sys_rst (rst),
      .flush   (flush),
      .bus     (bus16)
   );

   d16_decode_pipe #(.W(32), .SIGNED_IMM(1'b1)) u_dut32 (
      .sys_clk (clk),
      .sys_rst (rst),
      .flush   (flush),
      .bus     (bus32)
   );

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] q[$];
   bit          pend_acc, pend_pop, pend_fl, pend_rst;
   logic [31:0] pend_word;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int sx8(input logic [7:0] x);
      return (x >= 8'd128) ? int'(x) - 256 : int'(x);
   endfunction

   // Reference decode from the opcode table, done in plain integer arithmetic.
   function automatic void model_dec(input int w, input bit si, input logic [31:0] ins,
                                     output logic [31:0] a, output logic [31:0] b,
                                     output logic [31:0] c, output logic ill);
      logic [7:0]  op   = ins[31:24];
      logic [7:0]  fa   = ins[23:16];
      logic [7:0]  fb   = ins[15:8];
      logic [7:0]  fc   = ins[7:0];
      logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      int          imm  = int'(ins[15:0]);
      if (si && imm >= 32768) imm -= 65536;
      a = 32'h0; b = 32'h0; c = 32'h0; ill = 1'b0;
      if (op inside {OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_OR, OP_AND, OP_EQU,
                     OP_LTE, OP_GTE, OP_LT, OP_GT}) begin
         a = 32'(fa); b = 32'(fb); c = 32'(fc);
      end else if (op == OP_AFC || op == OP_LOD) begin
         a = 32'(fa); b = 32'(imm);
      end else if (op == OP_COP) begin
         a = 32'(fa); b = 32'(fb);
      end else if (op == OP_LOP) begin
         a = 32'(fa); b = 32'(sx8(fb)); c = 32'(fc);
      end else if (op == OP_STP) begin
         a = 32'(sx8(fa)); b = 32'(fb); c = 32'(fc);
      end else if (op == OP_STR || op == OP_JMZ) begin
         a = 32'(fa) * 256 + 32'(fb); b = 32'(fc);
      end else if (op == OP_JMP) begin
         a = 32'(fa) * 256 + 32'(fb);
      end else begin
         ill = 1'b1;
      end
      a &= mask; b &= mask; c &= mask;
   endfunction

   // One cycle: retire the previous edge into the model, drive, then check at negedge.
   task automatic step(input bit v, input logic [31:0] ins, input bit rdy,
                       input bit fl, input bit r);
      bit          exp_rdy;
      logic [31:0] head, ea, eb, ec;
      logic        ei;
      @(posedge clk);
      #1;
      if (pend_rst) q.delete();
      else begin
         if (pend_pop) void'(q.pop_front());
         if (pend_fl) q.delete();
         else if (pend_acc) q.push_back(pend_word);
      end
      in_valid = v; in_instr = ins; out_ready = rdy; flush = fl; rst = r;
      @(negedge clk);
      exp_rdy = !r && !fl && (q.size() < 2);
      chk("in_ready16", 32'(bus16.in_ready), 32'(exp_rdy));
      chk("in_ready32", 32'(bus32.in_ready), 32'(exp_rdy));
      chk("out_valid16", 32'(bus16.out_valid), 32'(q.size() != 0));
      chk("out_valid32", 32'(bus32.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         head = q[0];
         model_dec(16, 1'b0, head, ea, eb, ec, ei);
         chk("op16", 32'(bus16.out_op), 32'(head[31:24]));
         chk("a16", 32'(bus16.out_a), ea);
         chk("b16", 32'(bus16.out_b), eb);
         chk("c16", 32'(bus16.out_c), ec);
         chk("ill16", 32'(bus16.out_illegal), 32'(ei));
         model_dec(32, 1'b1, head, ea, eb, ec, ei);
         chk("op32", 32'(bus32.out_op), 32'(head[31:24]));
         chk("a32", bus32.out_a, ea);
         chk("b32", bus32.out_b, eb);
         chk("c32", bus32.out_c, ec);
         chk("ill32", 32'(bus32.out_illegal), 32'(ei));
      end
      pend_acc  = v && exp_rdy;
      pend_pop  = rdy && (q.size() != 0);
      pend_fl   = fl;
      pend_rst  = r;
      pend_word = ins;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_op16"},  32'(bus16.out_op), 32'h0);
      chk({tag, "_a16"},   32'(bus16.out_a), 32'h0);
      chk({tag, "_b16"},   32'(bus16.out_b), 32'h0);
      chk({tag, "_c16"},   32'(bus16.out_c), 32'h0);
      chk({tag, "_ill16"}, 32'(bus16.out_illegal), 32'h0);
      chk({tag, "_op32"},  32'(bus32.out_op), 32'h0);
      chk({tag, "_a32"},   bus32.out_a, 32'h0);
      chk({tag, "_b32"},   bus32.out_b, 32'h0);
      chk({tag, "_c32"},   bus32.out_c, 32'h0);
      chk({tag, "_ill32"}, 32'(bus32.out_illegal), 32'h0);
   endtask

   initial begin
      logic [7:0] legal [19] = '{OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_OR, OP_AND, OP_EQU,
                                 OP_LTE, OP_GTE, OP_LT, OP_GT, OP_AFC, OP_COP, OP_LOP,
                                 OP_STP, OP_LOD, OP_STR, OP_JMP, OP_JMZ};
      logic [7:0]  rop;
      logic [31:0] rword;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
      pend_acc = 1'b0; pend_pop = 1'b0; pend_fl = 1'b0; pend_rst = 1'b0; pend_word = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid16", 32'(bus16.out_valid), 32'h0);
      chk("rst_ready16", 32'(bus16.in_ready), 32'h0);
      chk("rst_valid32", 32'(bus32.out_valid), 32'h0);
      chk("rst_ready32", 32'(bus32.in_ready), 32'h0);
      chk_zero("rst");

      // ADD with one-cycle latency.
      step(1, 32'h0101_0203, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      chk("add_op16", 32'(bus16.out_op), 32'h01);
      chk("add_a16", 32'(bus16.out_a), 32'h0001);
      chk("add_b16", 32'(bus16.out_b), 32'h0002);
      chk("add_c16", 32'(bus16.out_c), 32'h0003);

      // AFC immediate: signed at W=32, unsigned at W=16.
      step(1, 32'h0C05_8001, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      chk("afc_b32", bus32.out_b, 32'hFFFF_8001);
      chk("afc_b16", 32'(bus16.out_b), 32'h0000_8001);
      chk("afc_c32", bus32.out_c, 32'h0);

      // Back-to-back STP, LOP, JMP, GT at full throughput.
      step(1, 32'h0FF0_1122, 1, 0, 0);
      step(1, 32'h0E00_8000, 1, 0, 0);
      chk("stp_a32", bus32.out_a, 32'hFFFF_FFF0);
      chk("stp_b32", bus32.out_b, 32'h11);
      chk("stp_c32", bus32.out_c, 32'h22);
      step(1, 32'h12AB_CD00, 1, 0, 0);
      chk("lop_b32", bus32.out_b, 32'hFFFF_FF80);
      step(1, 32'h0B00_0700, 1, 0, 0);
      chk("jmp_a32", bus32.out_a, 32'h0000_ABCD);
      step(0, 32'h0, 1, 0, 0);
      chk("gt_b32", bus32.out_b, 32'h7);

      // Illegal opcode still flows through.
      step(1, 32'hFF12_3456, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      chk("ill_flag32", 32'(bus32.out_illegal), 32'h1);
      chk("ill_op32", 32'(bus32.out_op), 32'hFF);
      chk("ill_a32", bus32.out_a, 32'h0);
      chk("ill_b32", bus32.out_b, 32'h0);
      step(0, 32'h0, 1, 0, 0);

      // Backpressure: only two words fit, then drain in order.
      step(1, 32'h0111_2233, 0, 0, 0);
      step(1, 32'h0244_5566, 0, 0, 0);
      step(1, 32'h0377_8899, 0, 0, 0);
      chk("bp_full16", 32'(bus16.in_ready), 32'h0);
      step(1, 32'h0377_8899, 1, 0, 0);
      step(1, 32'h0377_8899, 1, 0, 0);
      step(1, 32'h04AA_BBCC, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 1, 0, 0);

      // Flush with two words held.
      step(1, 32'h0501_0101, 0, 0, 0);
      step(1, 32'h0602_0202, 0, 0, 0);
      step(0, 32'h0, 0, 1, 0);
      step(0, 32'h0, 0, 0, 0);
      chk("flush_valid32", 32'(bus32.out_valid), 32'h0);
      chk("flush_ready32", 32'(bus32.in_ready), 32'h1);

      // Reset mid-stream.
      step(1, 32'h0703_0303, 0, 0, 0);
      step(1, 32'h0804_0404, 0, 0, 0);
      step(0, 32'h0, 1, 0, 1);
      step(0, 32'h0, 1, 0, 0);
      chk("mrst_valid16", 32'(bus16.out_valid), 32'h0);
      chk_zero("mrst");

      // Randomised traffic against the queue model.
      for (int i = 0; i < 600; i++) begin
         rop   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : legal[$urandom_range(0, 18)];
         rword = {rop, 24'($urandom)};
         step($urandom_range(0, 3) != 0, rword, $urandom_range(0, 2) != 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 96) == 0);
      end
      step(0, 32'h0, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
